traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl.sv | 139 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light FSM with pedestrian extension of the side green and a maintenance flash mode.
// Latency: outputs are registered and show the state entered on the same clock edge; phase_done is combinational.
// Backpressure: en=0 freezes state and counter (flash toggling continues); flash=1 overrides en.
module traffic_light_ctrl #(
    parameter int GREEN_T  = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int PED_EXT  = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic [2:0] state_o,
    output logic       phase_done
);

    typedef enum logic [2:0] {
        M_GRN   = 3'd0,
        M_YEL   = 3'd1,
        AR1     = 3'd2,
        S_GRN   = 3'd3,
        S_YEL   = 3'd4,
        AR2     = 3'd5,
        FLASH   = 3'd6,
        ILLEGAL = 3'd7
    } state_t;

    localparam logic [2:0] RED    = 3'b000;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] OFF    = 3'b100;

    state_t             state;
    state_t             nxt_state;
    logic [CNT_W-1:0]   cnt;
    logic               ped_pend;
    logic               grant;

    // Successor in the normal timed cycle; anything unexpected recovers via AR2.
    function automatic state_t seq_next(input state_t s);
        case (s)
            M_GRN:   return M_YEL;
            M_YEL:   return AR1;
            AR1:     return S_GRN;
            S_GRN:   return S_YEL;
            S_YEL:   return AR2;
            AR2:     return M_GRN;
            default: return AR2;
        endcase
    endfunction

    // Counter value loaded on entry: phase length minus one.
    function automatic logic [CNT_W-1:0] load_of(input state_t s, input logic g);
        case (s)
            M_GRN:        return CNT_W'(GREEN_T - 1);
            S_GRN:        return g ? CNT_W'(GREEN_T + PED_EXT - 1) : CNT_W'(GREEN_T - 1);
            M_YEL, S_YEL: return CNT_W'(YELLOW_T - 1);
            default:      return CNT_W'(ALLRED_T - 1);
        endcase
    endfunction

    // Light pair {main, side} shown in each timed state.
    function automatic logic [5:0] lights_of(input state_t s);
        case (s)
            M_GRN:   return {GREEN, RED};
            M_YEL:   return {YELLOW, RED};
            S_GRN:   return {RED, GREEN};
            S_YEL:   return {RED, YELLOW};
            default: return {RED, RED};
        endcase
    endfunction

    // Next timed state and pedestrian grant (a request on the entry edge itself counts).
    always_comb begin
        nxt_state = seq_next(state);
        grant     = ped_pend | ped_req;
    end

    assign phase_done = (cnt == '0) && en && (state != FLASH);
    assign state_o    = state;

    // Single FSM: state, phase counter, pedestrian latch and registered lights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= M_GRN;
            cnt        <= CNT_W'(GREEN_T - 1);
            main_light <= GREEN;
            side_light <= RED;
            ped_walk   <= 1'b0;
            ped_pend   <= 1'b0;
        end else begin
            if (ped_req) begin
                ped_pend <= 1'b1;
            end
            if (flash) begin
                // Flash takes over from any state; entry shows yellow, then alternates.
                state    <= FLASH;
                ped_walk <= 1'b0;
                if (state == FLASH) begin
                    main_light <= (main_light == YELLOW) ? OFF : YELLOW;
                    side_light <= (main_light == YELLOW) ? OFF : YELLOW;
                end else begin
                    main_light <= YELLOW;
                    side_light <= YELLOW;
                end
            end else if ((state == FLASH && en) || state == ILLEGAL) begin
                // Leave flash (or an illegal code) through a full all-red clearance.
                state      <= AR2;
                cnt        <= load_of(AR2, 1'b0);
                main_light <= RED;
                side_light <= RED;
                ped_walk   <= 1'b0;
            end else if (state == FLASH) begin
                // Frozen by en=0 but the lamps keep blinking.
                main_light <= (main_light == YELLOW) ? OFF : YELLOW;
                side_light <= (main_light == YELLOW) ? OFF : YELLOW;
            end else if (en) begin
                if (cnt == '0) begin
                    state                    <= nxt_state;
                    cnt                      <= load_of(nxt_state, grant);
                    {main_light, side_light} <= lights_of(nxt_state);
                    ped_walk                 <= (nxt_state == S_GRN) && grant;
                    if (nxt_state == S_GRN) begin
                        ped_pend <= 1'b0;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a phase/age reference model predicts outputs per edge.
// Latency: expectations are pushed at each rising edge and compared 1 time unit later.
// Backpressure: none; the DUT presents outputs every cycle, the monitor pops one entry per cycle.
module tb_traffic_light_ctrl;

    localparam int GT = 8;
    localparam int YT = 3;
    localparam int AT = 2;
    localparam int PE = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, ped_req, flash;
    logic [2:0] main_light, side_light, state_o;
    logic       ped_walk, phase_done;

    traffic_light_ctrl #(.GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .PED_EXT(PE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ped_req(ped_req), .flash(flash),
        .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk),
        .state_o(state_o), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase index, cycles already spent in it, and its length.
    typedef struct {
        int m; int s; int w; int st; int pd;
    } exp_t;
    exp_t exp_q[$];

    int m_p, m_age, m_len;
    bit m_pend, m_walk, m_fon;
    int main_tab[6] = '{1, 2, 0, 0, 0, 0};
    int side_tab[6] = '{0, 0, 0, 1, 2, 0};

    task automatic m_enter(input int s);
        m_p    = s;
        m_age  = 0;
        m_walk = 0;
        if (s == 0 || s == 3)      m_len = GT;
        else if (s == 1 || s == 4) m_len = YT;
        else                       m_len = AT;
        if (s == 3) begin
            m_walk = m_pend;
            if (m_walk) m_len = GT + PE;
            m_pend = 0;
        end
    endtask

    task automatic m_step(input bit e, input bit req, input bit fl);
        if (req) m_pend = 1;
        if (fl) begin
            if (m_p != 6) begin m_p = 6; m_fon = 1; end
            else m_fon = !m_fon;
            m_walk = 0;
        end else if (m_p == 6) begin
            if (e) m_enter(5);
            else m_fon = !m_fon;
        end else if (e) begin
            m_age++;
            if (m_age >= m_len) m_enter((m_p + 1) % 6);
        end
    endtask

    // Model process: advance on each edge using the inputs that were set up before it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_pend = 0;
                m_fon  = 0;
                m_enter(0);
            end else begin
                m_step(en, ped_req, flash);
            end
            if (m_p == 6) begin
                x.m = m_fon ? 2 : 4;
                x.s = x.m;
            end else begin
                x.m = main_tab[m_p];
                x.s = side_tab[m_p];
            end
            x.w  = m_walk;
            x.st = m_p;
            x.pd = (m_p != 6 && m_age == m_len - 1 && rst_n && en) ? 1 : 0;
            exp_q.push_back(x);
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation, away from the edge.
    initial begin
        exp_t y;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                y = exp_q.pop_front();
                chk("sb main_light", int'(main_light), y.m);
                chk("sb side_light", int'(side_light), y.s);
                chk("sb ped_walk",   int'(ped_walk),   y.w);
                chk("sb state_o",    int'(state_o),    y.st);
                chk("sb phase_done", int'(phase_done), y.pd);
            end
        end
    end

    task automatic wait_state(input int s, input string nm);
        int n = 0;
        while (int'(state_o) != s && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (int'(state_o) != s) begin
            checks++;
            fails++;
            $display("FAIL %s: timeout waiting for state %0d, got %0d", nm, s, state_o);
        end
    endtask

    task automatic phase_len(input int s, input string nm, input int exp_len, input int exp_walk);
        int len  = 0;
        int w_ok = 1;
        wait_state(s, nm);
        while (int'(state_o) == s && len < 300) begin
            len++;
            if (int'(ped_walk) != exp_walk) w_ok = 0;
            @(negedge clk);
        end
        chk({nm, " length"}, len, exp_len);
        chk({nm, " walk steady"}, w_ok, 1);
    endtask

    initial begin
        int n;
        int seq_s[7] = '{0, 1, 2, 3, 4, 5, 0};
        int seq_l[7] = '{GT, YT, AT, GT, YT, AT, GT};

        rst_n = 1'b1; en = 1'b0; ped_req = 1'b0; flash = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset main_light", int'(main_light), 1);
        chk("reset side_light", int'(side_light), 0);
        chk("reset ped_walk",   int'(ped_walk),   0);
        chk("reset state_o",    int'(state_o),    0);
        chk("reset phase_done", int'(phase_done), 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        rst_n = 1'b1;

        // Plain cycle with default timings.
        for (int i = 0; i < 7; i++) phase_len(seq_s[i], "cycle phase", seq_l[i], 0);

        // Pedestrian pulse during main yellow extends the next side green only.
        wait_state(1, "ped wait M_YEL");
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        phase_len(3, "ped S_GRN", GT + PE, 1);
        phase_len(3, "after-ped S_GRN", GT, 0);

        // Enable low for five cycles in main green stretches it to 13 cycles.
        wait_state(0, "hold wait M_GRN");
        n = 0;
        while (int'(state_o) == 0 && n < 100) begin
            n++;
            if (n == 3) en = 1'b0;
            if (n == 8) en = 1'b1;
            if (!en) chk("hold main_light", int'(main_light), 1);
            @(negedge clk);
        end
        chk("hold M_GRN length", n, GT + 5);

        // Flash during side green, then recovery through all-red.
        wait_state(3, "flash wait S_GRN");
        flash = 1'b1;
        @(negedge clk);
        chk("flash state", int'(state_o), 6);
        chk("flash main yellow", int'(main_light), 2);
        chk("flash side yellow", int'(side_light), 2);
        @(negedge clk);
        chk("flash main off", int'(main_light), 4);
        chk("flash side off", int'(side_light), 4);
        @(negedge clk);
        chk("flash main yellow again", int'(main_light), 2);
        flash = 1'b0;
        @(negedge clk);
        chk("unflash AR2", int'(state_o), 5);
        chk("unflash main red", int'(main_light), 0);
        chk("unflash side red", int'(side_light), 0);
        @(negedge clk);
        chk("unflash AR2 second cycle", int'(state_o), 5);
        @(negedge clk);
        chk("unflash M_GRN", int'(state_o), 0);

        // Asynchronous reset mid side yellow drops a pending request.
        wait_state(4, "reset wait S_YEL");
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset main", int'(main_light), 1);
        chk("async reset side", int'(side_light), 0);
        chk("async reset state", int'(state_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        phase_len(3, "post-reset S_GRN", GT, 0);

        // Request held across the side-green entry edge: granted, then re-armed.
        wait_state(2, "rearm wait AR1");
        ped_req = 1'b1;
        wait_state(3, "rearm wait S_GRN");
        n = 1;
        @(negedge clk);
        ped_req = 1'b0;
        while (int'(state_o) == 3 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("rearm granted S_GRN length", n, GT + PE);
        phase_len(3, "rearm second S_GRN", GT + PE, 1);
        phase_len(3, "rearm third S_GRN", GT, 0);

        // Randomized traffic: enable gaps, requests, flash episodes, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            ped_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) flash = !flash;
            if ($urandom_range(0, 299) == 0) #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        flash = 1'b0;
        en = 1'b1;
        ped_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
